// File: rtl/register_scoreboard_pkg.sv
// -----------------------------------------------------------------------------
// register_scoreboard_pkg
//
// Purpose : shared sizing constants and the data word type for the
//           architectural register file and its busy (reservation) table.
//
// Contents:
//   W_RD  - register-number width
//   W_OPR - operand/data width
//   N_REG - number of architectural registers (1 << W_RD)
//   WORD  - one register data word
//
// Optional feature macro used by the importing files: REGFILE_BYPASS_EN
// -----------------------------------------------------------------------------
package register_scoreboard_pkg;

  localparam int W_RD  = 5;
  localparam int W_OPR = 32;
  localparam int N_REG = 1 << W_RD;

  typedef logic [W_OPR-1:0] WORD;

endpackage : register_scoreboard_pkg

// File: rtl/register_scoreboard_reg_busy_table.sv
// -----------------------------------------------------------------------------
// reg_busy_table
//
// Purpose : one busy bit per architectural register. Writeback and cancel
//           release a register; a reservation sets it and wins over a release
//           of the same register in the same cycle. Also raises a sticky
//           protocol-error flag.
//
// Ports:
//   clk          in   clock, all updates on the rising edge
//   reset        in   synchronous, active-low reset
//   w_reserve_i  in   reserve register r0_i at this edge
//   r0_i         in   register to reserve
//   wb_i         in   writeback valid (releases wb_r_i)
//   wb_r_i       in   writeback register
//   cancel_i     in   cancel valid (releases cancel_r_i, no data write)
//   cancel_r_i   in   register to release
//   busy_o       out  current busy vector (registered)
//   err_o        out  sticky protocol-error flag
//
// Error sources (any one sets err_o until reset):
//   - writeback or cancel to a register that is not busy
//   - reserve of a register that is busy and not being released this cycle
//   - writeback and cancel naming the same register in one cycle
//
// Configuration macro: REGFILE_BYPASS_EN (not used inside this file; the
// bypass only affects how the top level interprets busy_o).
// -----------------------------------------------------------------------------
module reg_busy_table
  import register_scoreboard_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             w_reserve_i,
  input  logic [W_RD-1:0]  r0_i,
  input  logic             wb_i,
  input  logic [W_RD-1:0]  wb_r_i,
  input  logic             cancel_i,
  input  logic [W_RD-1:0]  cancel_r_i,
  output logic [N_REG-1:0] busy_o,
  output logic             err_o
);

  logic [N_REG-1:0] busy_q;
  logic [N_REG-1:0] busy_d;
  logic             err_q;
  logic             err_d;

  // One-hot decodes of the three update requests.
  logic [N_REG-1:0] wb_hit;
  logic [N_REG-1:0] cancel_hit;
  logic [N_REG-1:0] reserve_hit;
  logic [N_REG-1:0] release_hit;

  genvar gi;
  generate
    for (gi = 0; gi < N_REG; gi++) begin : g_entry
      assign wb_hit[gi]      = wb_i        && (wb_r_i     == W_RD'(gi));
      assign cancel_hit[gi]  = cancel_i    && (cancel_r_i == W_RD'(gi));
      assign reserve_hit[gi] = w_reserve_i && (r0_i       == W_RD'(gi));
      assign release_hit[gi] = wb_hit[gi] | cancel_hit[gi];

      // Reserve has the last word: a register released and re-reserved in
      // the same cycle belongs to the newly issued instruction.
      always_comb begin
        busy_d[gi] = busy_q[gi];
        if (release_hit[gi]) begin
          busy_d[gi] = 1'b0;
        end
        if (reserve_hit[gi]) begin
          busy_d[gi] = 1'b1;
        end
      end
    end
  endgenerate

  logic err_wb_idle;
  logic err_cancel_idle;
  logic err_double_reserve;
  logic err_wb_cancel_same;

  // All error checks look at the busy state before this edge's updates.
  assign err_wb_idle        = wb_i && !busy_q[wb_r_i];
  assign err_cancel_idle    = cancel_i && !busy_q[cancel_r_i];
  assign err_double_reserve = w_reserve_i && busy_q[r0_i] && !release_hit[r0_i];
  assign err_wb_cancel_same = wb_i && cancel_i && (wb_r_i == cancel_r_i);

  assign err_d = err_q | err_wb_idle | err_cancel_idle
               | err_double_reserve | err_wb_cancel_same;

  always_ff @(posedge clk) begin
    if (!reset) begin
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

  assign busy_o = busy_q;
  assign err_o  = err_q;

endmodule : reg_busy_table

// File: rtl/register_scoreboard.sv
// -----------------------------------------------------------------------------
// register_scoreboard
//
// Purpose : architectural register file plus per-register reservation table,
//           answering decode's operand reads and hazard query and accepting
//           writeback results and cancels. The read path is purely
//           combinational (no pipeline register).
//
// Ports:
//   clk          in   clock, all updates on the rising edge
//   reset        in   synchronous, active-low reset
//   rd_v_i       in   decode holds a valid instruction
//   r0_i         in   destination / first source register
//   r1_i         in   second source register
//   r_opr0_o     out  value of r0_i
//   r_opr1_o     out  value of r1_i
//   reserved_o   out  hazard: r0_i or r1_i has a pending write
//   w_reserve_i  in   reserve r0_i at this edge
//   wb_i         in   writeback valid
//   wb_r_i       in   writeback register
//   wb_data_i    in   writeback data
//   cancel_i     in   release a reservation without writing
//   cancel_r_i   in   register to release
//   err_o        out  sticky protocol-error flag
//
// Configuration macro: REGFILE_BYPASS_EN
//   defined   - a writeback is forwarded to the read ports and releases the
//               hazard in the same cycle (cancel is never forwarded)
//   undefined - reads see array contents only; the hazard clears the cycle
//               after the writeback edge
// -----------------------------------------------------------------------------
module register_scoreboard
  import register_scoreboard_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_v_i,
  input  logic [W_RD-1:0]   r0_i,
  input  logic [W_RD-1:0]   r1_i,
  output logic [W_OPR-1:0]  r_opr0_o,
  output logic [W_OPR-1:0]  r_opr1_o,
  output logic              reserved_o,
  input  logic              w_reserve_i,
  input  logic              wb_i,
  input  logic [W_RD-1:0]   wb_r_i,
  input  logic [W_OPR-1:0]  wb_data_i,
  input  logic              cancel_i,
  input  logic [W_RD-1:0]   cancel_r_i,
  output logic              err_o
);

  // ---------------------------------------------------------------------------
  // Data array. Every entry is cleared by reset, so it is kept in flops
  // rather than block RAM; the read ports are asynchronous.
  // ---------------------------------------------------------------------------
  WORD reg_q [N_REG];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < N_REG; i++) begin
        reg_q[i] <= '0;
      end
    end else if (wb_i) begin
      // Data is written even when the writeback is a protocol error.
      reg_q[wb_r_i] <= wb_data_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Reservation table
  // ---------------------------------------------------------------------------
  logic [N_REG-1:0] busy;

  reg_busy_table u_busy_table (
    .clk         (clk),
    .reset       (reset),
    .w_reserve_i (w_reserve_i),
    .r0_i        (r0_i),
    .wb_i        (wb_i),
    .wb_r_i      (wb_r_i),
    .cancel_i    (cancel_i),
    .cancel_r_i  (cancel_r_i),
    .busy_o      (busy),
    .err_o       (err_o)
  );

  // ---------------------------------------------------------------------------
  // Bypass: forwarding select per read port and the busy bits released early.
  // ---------------------------------------------------------------------------
  logic             byp0;
  logic             byp1;
  logic [N_REG-1:0] wb_release;

`ifdef REGFILE_BYPASS_EN
  assign byp0 = wb_i && (wb_r_i == r0_i);
  assign byp1 = wb_i && (wb_r_i == r1_i);

  genvar gi;
  generate
    for (gi = 0; gi < N_REG; gi++) begin : g_release
      assign wb_release[gi] = wb_i && (wb_r_i == W_RD'(gi));
    end
  endgenerate
`else
  assign byp0       = 1'b0;
  assign byp1       = 1'b0;
  assign wb_release = '0;
`endif

  logic [N_REG-1:0] busy_eff;
  assign busy_eff = busy & ~wb_release;

  assign r_opr0_o = byp0 ? wb_data_i : reg_q[r0_i];
  assign r_opr1_o = byp1 ? wb_data_i : reg_q[r1_i];

  // Both fields are always checked, even for forms that ignore r1_i; a busy
  // destination also stalls, keeping at most one write in flight per register.
  assign reserved_o = rd_v_i & (busy_eff[r0_i] | busy_eff[r1_i]);

endmodule : register_scoreboard

// File: tb/tb_register_scoreboard.sv
module tb_register_scoreboard;
  import register_scoreboard_pkg::*;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        rd_v_i;
  logic [4:0]  r0_i;
  logic [4:0]  r1_i;
  logic [31:0] r_opr0_o;
  logic [31:0] r_opr1_o;
  logic        reserved_o;
  logic        w_reserve_i;
  logic        wb_i;
  logic [4:0]  wb_r_i;
  logic [31:0] wb_data_i;
  logic        cancel_i;
  logic [4:0]  cancel_r_i;
  logic        err_o;

  always #5 clk = ~clk;

  register_scoreboard dut (
    .clk         (clk),
    .reset       (reset),
    .rd_v_i      (rd_v_i),
    .r0_i        (r0_i),
    .r1_i        (r1_i),
    .r_opr0_o    (r_opr0_o),
    .r_opr1_o    (r_opr1_o),
    .reserved_o  (reserved_o),
    .w_reserve_i (w_reserve_i),
    .wb_i        (wb_i),
    .wb_r_i      (wb_r_i),
    .wb_data_i   (wb_data_i),
    .cancel_i    (cancel_i),
    .cancel_r_i  (cancel_r_i),
    .err_o       (err_o)
  );

  // Reference model: register contents, pending-write flags, sticky error.
  logic [31:0] m_reg  [32];
  bit          m_busy [32];
  bit          m_err;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // A register counts as pending unless a forwarded writeback frees it now.
  function automatic bit pending(input logic [4:0] r, input bit wb, input logic [4:0] wbr);
    return m_busy[r] && !(BYP && wb && (wbr == r));
  endfunction

  function automatic bit exp_hazard(input bit rdv, input logic [4:0] r0, input logic [4:0] r1,
                                    input bit wb, input logic [4:0] wbr);
    return rdv && (pending(r0, wb, wbr) || pending(r1, wb, wbr));
  endfunction

  function automatic logic [31:0] exp_read(input logic [4:0] r, input bit wb,
                                           input logic [4:0] wbr, input logic [31:0] wbd);
    return (BYP && wb && (wbr == r)) ? wbd : m_reg[r];
  endfunction

  // Drive one cycle's inputs after the falling edge and check the
  // combinational outputs against the model.
  task automatic drive(input bit rdv, input logic [4:0] r0, input logic [4:0] r1, input bit res,
                       input bit wb, input logic [4:0] wbr, input logic [31:0] wbd,
                       input bit can, input logic [4:0] canr);
    @(negedge clk);
    rd_v_i = rdv; r0_i = r0; r1_i = r1; w_reserve_i = res;
    wb_i = wb; wb_r_i = wbr; wb_data_i = wbd; cancel_i = can; cancel_r_i = canr;
    #1;
    check("opr0", r_opr0_o, exp_read(r0, wb, wbr, wbd));
    check("opr1", r_opr1_o, exp_read(r1, wb, wbr, wbd));
    check("reserved", {31'd0, reserved_o}, {31'd0, exp_hazard(rdv, r0, r1, wb, wbr)});
    check("err", {31'd0, err_o}, {31'd0, m_err});
  endtask

  // Clock edge: apply the architectural rules to the model.
  task automatic commit();
    bit e;
    bit nb [32];
    @(posedge clk);
    e = 1'b0;
    if (wb_i && !m_busy[wb_r_i]) e = 1'b1;
    if (cancel_i && !m_busy[cancel_r_i]) e = 1'b1;
    if (wb_i && cancel_i && (wb_r_i == cancel_r_i)) e = 1'b1;
    if (w_reserve_i && m_busy[r0_i] &&
        !((wb_i && wb_r_i == r0_i) || (cancel_i && cancel_r_i == r0_i))) e = 1'b1;
    nb = m_busy;
    if (wb_i) begin
      m_reg[wb_r_i] = wb_data_i;
      nb[wb_r_i] = 1'b0;
    end
    if (cancel_i) nb[cancel_r_i] = 1'b0;
    if (w_reserve_i) nb[r0_i] = 1'b1;
    m_busy = nb;
    m_err = m_err | e;
    $display("[TB] t=%0t rdv=%0d r0=%0d r1=%0d res=%0d wb=%0d/%0d/%h can=%0d/%0d",
             $time, rd_v_i, r0_i, r1_i, w_reserve_i, wb_i, wb_r_i, wb_data_i, cancel_i, cancel_r_i);
  endtask

  task automatic step(input bit rdv, input logic [4:0] r0, input logic [4:0] r1, input bit res,
                      input bit wb, input logic [4:0] wbr, input logic [31:0] wbd,
                      input bit can, input logic [4:0] canr);
    drive(rdv, r0, r1, res, wb, wbr, wbd, can, canr);
    commit();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    rd_v_i = 0; r0_i = 0; r1_i = 0; w_reserve_i = 0;
    wb_i = 0; wb_r_i = 0; wb_data_i = 0; cancel_i = 0; cancel_r_i = 0;
    @(posedge clk);
    for (int i = 0; i < 32; i++) begin
      m_reg[i] = '0;
      m_busy[i] = 1'b0;
    end
    m_err = 1'b0;
    #1 reset = 1'b1;
    $display("[TB] t=%0t reset", $time);
  endtask

  initial begin
    reset = 1'b0;
    rd_v_i = 0; r0_i = 0; r1_i = 0; w_reserve_i = 0;
    wb_i = 0; wb_r_i = 0; wb_data_i = 0; cancel_i = 0; cancel_r_i = 0;
    do_reset();

    // Reset state
    drive(1, 5'd3, 5'd7, 0, 0, 0, 0, 0, 0);
    check("rst_opr0", r_opr0_o, 32'h0);
    check("rst_opr1", r_opr1_o, 32'h0);
    check("rst_reserved", {31'd0, reserved_o}, 32'd0);
    check("rst_err", {31'd0, err_o}, 32'd0);
    commit();

    // Reserve r5, then observe hazard until writeback
    step(1, 5'd5, 5'd0, 1, 0, 0, 0, 0, 0);
    drive(1, 5'd1, 5'd5, 0, 0, 0, 0, 0, 0);
    check("r5_hazard", {31'd0, reserved_o}, 32'd1);
    commit();
    drive(0, 5'd1, 5'd5, 0, 0, 0, 0, 0, 0);
    check("r5_rdv0", {31'd0, reserved_o}, 32'd0);
    commit();
    drive(1, 5'd1, 5'd5, 0, 1, 5'd5, 32'hDEADBEEF, 0, 0);
    check("r5_wb_reserved", {31'd0, reserved_o}, BYP ? 32'd0 : 32'd1);
    check("r5_wb_opr1", r_opr1_o, BYP ? 32'hDEADBEEF : 32'h0);
    commit();
    drive(1, 5'd1, 5'd5, 0, 0, 0, 0, 0, 0);
    check("r5_after_reserved", {31'd0, reserved_o}, 32'd0);
    check("r5_after_opr1", r_opr1_o, 32'hDEADBEEF);
    commit();

    // Same-cycle writeback and re-reserve of r9
    step(1, 5'd9, 5'd0, 1, 0, 0, 0, 0, 0);
    step(1, 5'd9, 5'd0, 1, 1, 5'd9, 32'h12345678, 0, 0);
    drive(1, 5'd9, 5'd0, 0, 0, 0, 0, 0, 0);
    check("r9_data", r_opr0_o, 32'h12345678);
    check("r9_busy", {31'd0, reserved_o}, 32'd1);
    check("r9_err", {31'd0, err_o}, 32'd0);
    commit();
    step(0, 0, 0, 0, 1, 5'd9, 32'h00009999, 0, 0);

    // Cancel of r2 keeps its data
    step(1, 5'd2, 5'd0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 5'd2, 32'hA5A5A5A5, 0, 0);
    step(1, 5'd2, 5'd0, 1, 0, 0, 0, 0, 0);
    drive(1, 5'd0, 5'd2, 0, 0, 0, 0, 1, 5'd2);
    check("r2_cancel_cycle", {31'd0, reserved_o}, 32'd1);
    commit();
    drive(1, 5'd0, 5'd2, 0, 0, 0, 0, 0, 0);
    check("r2_released", {31'd0, reserved_o}, 32'd0);
    check("r2_data_kept", r_opr1_o, 32'hA5A5A5A5);
    check("r2_err", {31'd0, err_o}, 32'd0);
    commit();

    // Writeback to the unreserved r4: data lands, error is sticky
    drive(0, 0, 0, 0, 1, 5'd4, 32'h00000044, 0, 0);
    check("r4_err_before", {31'd0, err_o}, 32'd0);
    commit();
    drive(1, 5'd4, 5'd4, 0, 0, 0, 0, 0, 0);
    check("r4_data", r_opr0_o, 32'h00000044);
    check("r4_err_set", {31'd0, err_o}, 32'd1);
    commit();
    step(1, 5'd1, 5'd2, 1, 0, 0, 0, 0, 0);
    drive(1, 5'd3, 5'd3, 0, 0, 0, 0, 0, 0);
    check("r4_err_held", {31'd0, err_o}, 32'd1);
    commit();
    do_reset();
    drive(1, 5'd4, 5'd1, 0, 0, 0, 0, 0, 0);
    check("rst2_opr0", r_opr0_o, 32'h0);
    check("rst2_reserved", {31'd0, reserved_o}, 32'd0);
    check("rst2_err", {31'd0, err_o}, 32'd0);
    commit();

    // Randomized traffic, mostly protocol-conforming
    for (int n = 0; n < 1500; n++) begin
      if (n % 250 == 249) begin
        do_reset();
      end else begin
        bit          rdv, res, wb, can;
        logic [4:0]  r0, r1, wbr, canr;
        logic [31:0] wbd;
        int          q[$];
        rdv = 1'($urandom_range(0, 1));
        r0  = 5'($urandom_range(0, 31));
        r1  = 5'($urandom_range(0, 31));
        wbd = $urandom;
        for (int i = 0; i < 32; i++) if (m_busy[i]) q.push_back(i);
        wb = 0; wbr = 0; can = 0; canr = 0;
        if (q.size() > 0 && $urandom_range(0, 1) == 1) begin
          wb = 1; wbr = 5'(q[$urandom_range(0, q.size() - 1)]);
        end
        if (q.size() > 1 && $urandom_range(0, 3) == 0) begin
          canr = 5'(q[$urandom_range(0, q.size() - 1)]);
          can = !(wb && canr == wbr);
        end
        if ($urandom_range(0, 63) == 0) begin
          wb = 1; wbr = 5'($urandom_range(0, 31));
        end
        res = rdv && !exp_hazard(rdv, r0, r1, wb, wbr) && ($urandom_range(0, 1) == 1);
        step(rdv, r0, r1, res, wb, wbr, wbd, can, canr);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_register_scoreboard

// File: doc/register_scoreboard.md
# register_scoreboard

Architectural register file paired with a per-register busy (reservation) table, acting as the responder for the decode stage's operand-read and write-reservation requests. Decode presents two source/destination register numbers and receives the operand values plus a hazard flag. It reserves its destination when it issues. The writeback stage writes the result and releases the reservation; a cancel port releases reservations of instructions killed downstream. The block sits between decode and writeback and has no pipeline register of its own on the read path.

## Interface
Parameters:
- W_RD, 5, register-number width
- W_OPR, 32, operand/data width
- N_REG, 1 << W_RD, number of architectural registers

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-low reset
- rd_v_i  in  1  decode holds a valid instruction this cycle
- r0_i  in  W_RD  first register number (destination and first source)
- r1_i  in  W_RD  second source register number
- r_opr0_o  out  W_OPR  value of register r0_i
- r_opr1_o  out  W_OPR  value of register r1_i
- reserved_o  out  1  hazard: r0_i or r1_i has a pending write
- w_reserve_i  in  1  reserve register r0_i at this edge
- wb_i  in  1  writeback valid
- wb_r_i  in  W_RD  writeback register
- wb_data_i  in  W_OPR  writeback data
- cancel_i  in  1  release reservation without writing
- cancel_r_i  in  W_RD  register to release
- err_o  out  1  sticky protocol-error flag

## Operation
- State: reg array of N_REG x W_OPR and busy vector of N_REG bits.
- Reads are combinational from the array, gated by bypass when configured.
- reserved_o = rd_v_i & (busy_eff[r0_i] | busy_eff[r1_i]). Both fields are always checked, including for immediate forms, so the check is conservative. busy_eff is the busy bit, minus the bypass release when configured.
- A busy destination (r0_i) is a hazard, so there is at most one outstanding write per register. One busy bit is enough.
- Edge updates, in priority order per register:
  - Writeback: when wb_i, reg[wb_r_i] <= wb_data_i and busy[wb_r_i] <= 0.
  - Cancel: when cancel_i, busy[cancel_r_i] <= 0. Register data is unchanged.
  - Reserve: when w_reserve_i, busy[r0_i] <= 1. Reserve wins over writeback or cancel to the same register in the same cycle.
- Register 0 is an ordinary register, not hardwired.
- err_o is set and held until reset on any of:
  - wb_i or cancel_i to a register whose busy bit is 0;
  - w_reserve_i to a register already busy and not released that cycle;
  - wb_i and cancel_i to the same register in the same cycle.
- An error never blocks the data write.

## Timing
- Reset (reset=0 at an edge): every reg entry is 0, the busy vector is all 0, err_o is 0. Read outputs therefore show 0 in the cycle after reset.
- Read latency: 0 cycles (combinational).
- A reservation is visible on reserved_o in the cycle after the w_reserve_i edge.
- A release at edge N clears the hazard from cycle N+1, or in cycle N when bypass is enabled.
- reserved_o depends combinationally on rd_v_i, r0_i, r1_i, wb_i/wb_r_i (bypass only) and state. It has no dependence on w_reserve_i.
- Reset mid-operation discards all reservations and data. Upstream must flush in-flight instructions together with reset.

## Configuration
- REGFILE_BYPASS_EN defined:
  - When wb_i matches r0_i or r1_i, the read returns wb_data_i in that same cycle.
  - busy_eff excludes wb_r_i while wb_i is high.
  - Cancel is never bypassed.
- REGFILE_BYPASS_EN undefined:
  - Reads return array contents only.
  - reserved_o stays asserted through the writeback cycle, which costs one extra decode stall per dependent instruction.

## Structure
- The shared package holds W_RD, W_OPR, N_REG and WORD.
- Sub-module reg_busy_table holds the busy vector with its reserve/release/cancel priority logic and the err_o generation. The top level holds the data array, read muxes and bypass.

## Test plan
- Reset, then read r0_i=3, r1_i=7 with rd_v_i=1: r_opr0_o=r_opr1_o=0, reserved_o=0, err_o=0.
- Reserve r5, then read r0_i=1, r1_i=5 with rd_v_i=1:
  - reserved_o=1 until wb_i with wb_r_i=5, wb_data_i=32'hDEADBEEF.
  - Bypass enabled: reserved_o=0 and r_opr1_o=32'hDEADBEEF in the writeback cycle.
  - Bypass disabled: both take effect the following cycle.
- Same read with rd_v_i=0 while r5 is busy: reserved_o=0.
- Same-cycle wb_i to r9 and w_reserve_i to r9: r9 data is updated, busy[r9]=1 afterwards, err_o=0.
- Reserve r2, then cancel_i with cancel_r_i=2: busy cleared, r2 data unchanged, reserved_o for r1_i=2 drops the next cycle.
- wb_i to the unreserved r4: data written and err_o=1, held through later traffic until reset.
